// File: rtl/pipe_ctrl.sv
// Sequencing controller for the 5-stage core: run/halt/step FSM, load-use stall and branch flush control.
// Optional performance counters are built only when PIPE_CTRL_PERF_CNT_EN is defined.
module pipe_ctrl #(
    parameter int DRAIN_CYCLES = 4,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             run,
    input  logic             halt_req,
    input  logic             step,
    input  logic [4:0]       ID_rs,
    input  logic [4:0]       ID_rt,
    input  logic [4:0]       EX_rt,
    input  logic             EX_MemRead,
    input  logic             MEM_branch_taken,
    output logic             pc_write,
    output logic             ifid_write,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             exmem_flush,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] cycle_count,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] flush_count
);

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        RUN    = 2'b01,
        DRAIN  = 2'b10,
        HALTED = 2'b11
    } state_t;

    localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [DW-1:0] DRAIN_LOAD = DW'(DRAIN_CYCLES - 1);

    state_t        state_reg;
    logic [DW-1:0] drain_reg;

    logic active;
    logic load_use;
    logic stall_cycle;
    logic branch_flush;

    assign state = state_reg;

    // An active cycle advances the pipeline: normal running, or one step while halted.
    assign active   = (state_reg == RUN) || ((state_reg == HALTED) && step);
    assign load_use = EX_MemRead && (EX_rt != 5'd0) && ((EX_rt == ID_rs) || (EX_rt == ID_rt));

    // The branch flush squashes the stalled instruction, so it overrides the stall.
    assign stall_cycle  = active && load_use && !MEM_branch_taken;
    assign branch_flush = (active || (state_reg == DRAIN)) && MEM_branch_taken;

    always_comb begin
        pc_write    = 1'b0;
        ifid_write  = 1'b0;
        ifid_flush  = 1'b0;
        idex_flush  = 1'b0;
        exmem_flush = 1'b0;
        if (active) begin
            pc_write   = 1'b1;
            ifid_write = 1'b1;
            if (MEM_branch_taken) begin
                ifid_flush  = 1'b1;
                idex_flush  = 1'b1;
                exmem_flush = 1'b1;
            end else if (load_use) begin
                pc_write   = 1'b0;
                ifid_write = 1'b0;
                idex_flush = 1'b1;
            end
        end else if (state_reg == DRAIN) begin
            // Bubbles enter at IFID; a resolving branch still loads its target into the PC.
            ifid_write = 1'b1;
            ifid_flush = 1'b1;
            if (MEM_branch_taken) begin
                pc_write    = 1'b1;
                idex_flush  = 1'b1;
                exmem_flush = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= IDLE;
            drain_reg <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (run) state_reg <= RUN;
                end
                RUN: begin
                    if (halt_req) begin
                        state_reg <= DRAIN;
                        drain_reg <= DRAIN_LOAD;
                    end
                end
                DRAIN: begin
                    if (drain_reg == '0) state_reg <= HALTED;
                    else                 drain_reg <= drain_reg - DW'(1);
                end
                HALTED: begin
                    if (run && !halt_req) state_reg <= RUN;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

`ifdef PIPE_CTRL_PERF_CNT_EN
    logic [CNT_W-1:0] cycle_reg;
    logic [CNT_W-1:0] stall_reg;
    logic [CNT_W-1:0] flush_reg;

    // Counters saturate rather than wrap so long runs never read as short ones.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cycle_reg <= '0;
            stall_reg <= '0;
            flush_reg <= '0;
        end else begin
            if ((state_reg == RUN) && (cycle_reg != '1)) cycle_reg <= cycle_reg + CNT_W'(1);
            if (stall_cycle && (stall_reg != '1))        stall_reg <= stall_reg + CNT_W'(1);
            if (branch_flush && (flush_reg != '1))       flush_reg <= flush_reg + CNT_W'(1);
        end
    end

    assign cycle_count = cycle_reg;
    assign stall_count = stall_reg;
    assign flush_count = flush_reg;
`else
    logic unused_perf;
    assign unused_perf = stall_cycle ^ branch_flush;
    assign cycle_count = '0;
    assign stall_count = '0;
    assign flush_count = '0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Randomized self-checking bench for pipe_ctrl against a behavioural sequencing model.
module tb_pipe_ctrl;

    localparam int DRAIN_CYCLES = 4;
    localparam int CNT_W        = 16;

    logic             clk = 1'b0;
    logic             reset;
    logic             run, halt_req, step;
    logic [4:0]       ID_rs, ID_rt, EX_rt;
    logic             EX_MemRead, MEM_branch_taken;
    logic             pc_write, ifid_write, ifid_flush, idex_flush, exmem_flush;
    logic [1:0]       state;
    logic [CNT_W-1:0] cycle_count, stall_count, flush_count;

    int total = 0;
    int bad   = 0;

    // Model: 0=IDLE 1=RUN 2=DRAIN 3=HALTED; m_left = drain cycles still to spend.
    int m_st, m_left, m_cyc, m_stall, m_flush;

    pipe_ctrl #(.DRAIN_CYCLES(DRAIN_CYCLES), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .run(run), .halt_req(halt_req), .step(step),
        .ID_rs(ID_rs), .ID_rt(ID_rt), .EX_rt(EX_rt), .EX_MemRead(EX_MemRead),
        .MEM_branch_taken(MEM_branch_taken),
        .pc_write(pc_write), .ifid_write(ifid_write), .ifid_flush(ifid_flush),
        .idex_flush(idex_flush), .exmem_flush(exmem_flush), .state(state),
        .cycle_count(cycle_count), .stall_count(stall_count), .flush_count(flush_count)
    );

    always #5 clk = ~clk;

    function automatic bit m_lu();
        return EX_MemRead && (EX_rt != 0) && (EX_rt == ID_rs || EX_rt == ID_rt);
    endfunction

    function automatic bit m_active();
        return (m_st == 1) || (m_st == 3 && step);
    endfunction

    // {pc_write, ifid_write, ifid_flush, idex_flush, exmem_flush, state}
    function automatic logic [6:0] model_out();
        bit br = MEM_branch_taken;
        logic [1:0] s = 2'(m_st);
        if (m_active()) begin
            if (br)         return {5'b11111, s};
            else if (m_lu()) return {5'b00010, s};
            else            return {5'b11000, s};
        end
        if (m_st == 2) return {br, 1'b1, 1'b1, br, br, s};
        return {5'b00000, s};
    endfunction

    function automatic logic [6:0] obs_out();
        return {pc_write, ifid_write, ifid_flush, idex_flush, exmem_flush, state};
    endfunction

    function automatic int sat(input int v);
        return (v >= (1 << CNT_W) - 1) ? (1 << CNT_W) - 1 : v + 1;
    endfunction

    task automatic model_reset();
        m_st = 0; m_left = 0; m_cyc = 0; m_stall = 0; m_flush = 0;
    endtask

    task automatic model_advance();
        bit act = m_active();
        if (m_st == 1) m_cyc = sat(m_cyc);
        if (act && m_lu() && !MEM_branch_taken) m_stall = sat(m_stall);
        if ((act || m_st == 2) && MEM_branch_taken) m_flush = sat(m_flush);
        case (m_st)
            0: if (run) m_st = 1;
            1: if (halt_req) begin m_st = 2; m_left = DRAIN_CYCLES; end
            2: begin m_left--; if (m_left == 0) m_st = 3; end
            3: if (run && !halt_req) m_st = 1;
            default: m_st = 0;
        endcase
    endtask

    task automatic drive(input bit r, input bit h, input bit s, input bit mr,
                         input int rs, input int rt, input int ert, input bit br);
        run = r; halt_req = h; step = s; EX_MemRead = mr;
        ID_rs = 5'(rs); ID_rt = 5'(rt); EX_rt = 5'(ert); MEM_branch_taken = br;
    endtask

    // Called at posedge+1; leaves at the following posedge+1 with the model advanced.
    task automatic tick();
        @(posedge clk);
        model_advance();
        #1;
    endtask

    task automatic test_reset();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        reset = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        total++;
        if (obs_out() !== 7'b0) begin
            bad++; $display("FAIL reset_outputs got=%b want=%b", obs_out(), 7'b0);
        end
        total++;
        if ({cycle_count, stall_count, flush_count} !== '0) begin
            bad++; $display("FAIL reset_counters got=%0d/%0d/%0d want=0/0/0", cycle_count, stall_count, flush_count);
        end
        reset = 1'b0;
        drive(0, 1, 1, 1, 3, 3, 3, 0);
        tick();
        total++;
        if (state !== 2'b00) begin
            bad++; $display("FAIL idle_ignores_halt_step got=%b want=00", state);
        end
        $display("test_reset done");
    endtask

    task automatic test_start();
        drive(1, 0, 0, 0, 0, 0, 0, 0);
        tick();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        #4;
        total++;
        if (obs_out() !== 7'b1100001) begin
            bad++; $display("FAIL start_run got=%b want=%b", obs_out(), 7'b1100001);
        end
        tick();
        $display("test_start done");
    endtask

    task automatic test_load_use();
        drive(0, 0, 0, 1, 5, 0, 5, 0);
        #4;
        total++;
        if (obs_out() !== 7'b0001001) begin
            bad++; $display("FAIL load_use_rs got=%b want=%b", obs_out(), 7'b0001001);
        end
        tick();
        drive(0, 0, 0, 1, 0, 0, 0, 0);
        #4;
        total++;
        if (obs_out() !== 7'b1100001) begin
            bad++; $display("FAIL load_use_r0 got=%b want=%b", obs_out(), 7'b1100001);
        end
        tick();
        for (int i = 0; i < 60; i++) begin
            drive(0, 0, 0, 1'($urandom_range(0, 1)), $urandom_range(0, 3),
                  $urandom_range(0, 3), $urandom_range(0, 3), 0);
            #4;
            total++;
            if (obs_out() !== model_out()) begin
                bad++; $display("FAIL load_use_rand[%0d] got=%b want=%b", i, obs_out(), model_out());
            end
            tick();
        end
        $display("test_load_use done");
    endtask

    task automatic test_branch();
        drive(0, 0, 0, 1, 7, 9, 7, 1);
        #4;
        total++;
        if (obs_out() !== 7'b1111101) begin
            bad++; $display("FAIL branch_over_stall got=%b want=%b", obs_out(), 7'b1111101);
        end
        tick();
        drive(0, 0, 0, 0, 1, 2, 3, 1);
        #4;
        total++;
        if (obs_out() !== 7'b1111101) begin
            bad++; $display("FAIL branch_plain got=%b want=%b", obs_out(), 7'b1111101);
        end
        tick();
        $display("test_branch done");
    endtask

    task automatic test_halt_drain();
        drive(1, 1, 0, 0, 0, 0, 0, 0);  // halt wins over run
        tick();
        for (int c = 1; c <= DRAIN_CYCLES; c++) begin
            drive(1, 0, 1, 1, 4, 4, 4, (c == 2));
            #4;
            total++;
            if (obs_out() !== {(c == 2), 1'b1, 1'b1, (c == 2), (c == 2), 2'b10}) begin
                bad++; $display("FAIL drain_cycle[%0d] got=%b want=%b", c, obs_out(), model_out());
            end
            tick();
        end
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        #4;
        total++;
        if (obs_out() !== 7'b0000011) begin
            bad++; $display("FAIL halted_entry got=%b want=%b", obs_out(), 7'b0000011);
        end
        tick();
        $display("test_halt_drain done");
    endtask

    task automatic test_step();
        int adv = 0;
        for (int p = 0; p < 3; p++) begin
            for (int k = 0; k < 3; k++) begin
                drive(0, 0, (k == 0), 0, 1, 2, 3, 0);
                #4;
                if (pc_write) adv++;
                total++;
                if (obs_out() !== model_out()) begin
                    bad++; $display("FAIL step[%0d.%0d] got=%b want=%b", p, k, obs_out(), model_out());
                end
                tick();
            end
        end
        total++;
        if (adv != 3 || state !== 2'b11) begin
            bad++; $display("FAIL step_count got=%0d/%b want=3/11", adv, state);
        end
        drive(1, 0, 0, 0, 0, 0, 0, 0);
        tick();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        #4;
        total++;
        if (state !== 2'b01) begin
            bad++; $display("FAIL resume_run got=%b want=01", state);
        end
        tick();
        $display("test_step done");
    endtask

    task automatic test_back_to_back();
        drive(0, 1, 0, 0, 0, 0, 0, 0);
        tick();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        repeat (DRAIN_CYCLES) tick();
        drive(1, 0, 1, 1, 6, 0, 6, 0);  // step with load-use stall and run together
        #4;
        total++;
        if (obs_out() !== 7'b0001011) begin
            bad++; $display("FAIL step_run_stall got=%b want=%b", obs_out(), 7'b0001011);
        end
        tick();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        #4;
        total++;
        if (state !== 2'b01) begin
            bad++; $display("FAIL step_run_state got=%b want=01", state);
        end
        tick();
        $display("test_back_to_back done");
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            drive(($urandom_range(0, 7) == 0), ($urandom_range(0, 11) == 0), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), $urandom_range(0, 3), $urandom_range(0, 3),
                  $urandom_range(0, 3), ($urandom_range(0, 5) == 0));
            #4;
            total++;
            if (obs_out() !== model_out()) begin
                bad++; $display("FAIL rand_out[%0d] got=%b want=%b", i, obs_out(), model_out());
            end
`ifdef PIPE_CTRL_PERF_CNT_EN
            total++;
            if (cycle_count !== CNT_W'(m_cyc) || stall_count !== CNT_W'(m_stall) || flush_count !== CNT_W'(m_flush)) begin
                bad++; $display("FAIL rand_cnt[%0d] got=%0d/%0d/%0d want=%0d/%0d/%0d", i,
                                cycle_count, stall_count, flush_count, m_cyc, m_stall, m_flush);
            end
`endif
            tick();
        end
        $display("test_random done");
    endtask

    task automatic test_async_reset();
        int exp_c, exp_s;
        drive(1, 0, 0, 0, 0, 0, 0, 0);
        while (m_st != 1) tick();
        drive(0, 1, 0, 0, 0, 0, 0, 0);
        tick();
        drive(0, 0, 0, 1, 2, 2, 2, 0);
        tick();
        #2;
        reset = 1'b1;
        model_reset();
        #1;
        total++;
        if (state !== 2'b00 || pc_write !== 1'b0 || ifid_flush !== 1'b0) begin
            bad++; $display("FAIL async_reset got=%b want=%b", obs_out(), 7'b0);
        end
        total++;
        if ({cycle_count, stall_count, flush_count} !== '0) begin
            bad++; $display("FAIL async_reset_cnt got=%0d/%0d/%0d want=0/0/0", cycle_count, stall_count, flush_count);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        drive(1, 0, 0, 0, 0, 0, 0, 0);
        tick();
        for (int i = 0; i < 10; i++) begin
            drive(0, 0, 0, (i == 3 || i == 7), 9, 1, 9, 0);
            tick();
        end
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        #4;
`ifdef PIPE_CTRL_PERF_CNT_EN
        exp_c = 10; exp_s = 2;
`else
        exp_c = 0; exp_s = 0;
`endif
        total++;
        if (cycle_count !== CNT_W'(exp_c) || stall_count !== CNT_W'(exp_s)) begin
            bad++; $display("FAIL perf_counts got=%0d/%0d want=%0d/%0d", cycle_count, stall_count, exp_c, exp_s);
        end
        tick();
        $display("test_async_reset done");
    endtask

    initial begin
        #1;
        test_reset();
        test_start();
        test_load_use();
        test_branch();
        test_halt_drain();
        test_step();
        test_back_to_back();
        test_random();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
- Central sequencing controller for the 5-stage 8-bit pipelined core (IF/ID/EX/MEM/WB).
- Owns the run/halt/single-step state machine.
- Detects load-use hazards and drives the stall signals.
- Drives the flush signals when a taken branch resolves in MEM.
- Its outputs gate the PC write enable and the write/flush controls of the IFID, IDEX and EXMEM pipeline registers.

Parameters:
- DRAIN_CYCLES, 4: number of bubble cycles inserted in DRAIN before entering HALTED.
- CNT_W, 16: width of the performance counters (used only with the optional feature).

Ports:
- clk  input  1  core clock; all state updates on rising edge
- reset  input  1  asynchronous, active-high; forces IDLE and clears all state
- run  input  1  level; start or resume execution
- halt_req  input  1  level; request halt after draining the pipeline
- step  input  1  single-cycle pulse; advance the pipeline one clock while HALTED
- ID_rs  input  5  rs field of the instruction in ID
- ID_rt  input  5  rt field of the instruction in ID
- EX_rt  input  5  rt field of the instruction in EX
- EX_MemRead  input  1  the instruction in EX is a load
- MEM_branch_taken  input  1  ((MEM_zr ^ MEM_BranchFlip) & MEM_Branch) is 1
- pc_write  output  1  PC load enable
- ifid_write  output  1  IFID register hold when 0
- ifid_flush  output  1  IFID register loads a NOP
- idex_flush  output  1  IDEX register loads zeroed controls (bubble)
- exmem_flush  output  1  EXMEM register loads zeroed controls
- state  output  2  IDLE=00, RUN=01, DRAIN=10, HALTED=11
- cycle_count  output  CNT_W  see Optional Feature
- stall_count  output  CNT_W  see Optional Feature
- flush_count  output  CNT_W  see Optional Feature

Behaviour:
- Reset: state=IDLE; drain counter=0; counters=0.
- Reset values of outputs in IDLE: pc_write=0, ifid_write=0, all flushes=0.
- Output timing: Mealy. Outputs decode combinationally from the registered state and the current hazard inputs, so a stall takes effect in the same cycle it is detected.
- Frozen (IDLE, HALTED without step): pc_write=0, ifid_write=0, all flushes=0.
- Active (RUN, or HALTED with step=1): defaults are pc_write=1, ifid_write=1, flushes=0.
  - Load-use hazard: EX_MemRead=1, EX_rt!=0, and EX_rt==ID_rs or EX_rt==ID_rt. Response: pc_write=0, ifid_write=0, idex_flush=1 (1-cycle stall).
  - Branch taken (MEM_branch_taken=1): pc_write=1, ifid_write=1, ifid_flush=1, idex_flush=1, exmem_flush=1.
  - Branch taken has priority over load-use (the stalled instruction is being flushed anyway).
- DRAIN: pc_write=0, ifid_write=1, ifid_flush=1 every cycle, injecting bubbles.
  - If MEM_branch_taken=1 during DRAIN: pc_write=1 and idex_flush=exmem_flush=1 for that cycle, so the PC holds the branch target on resume.
- Transitions:
  - IDLE: run=1 -> RUN. halt_req and step are ignored.
  - RUN: halt_req=1 -> DRAIN; load drain counter with DRAIN_CYCLES-1. halt_req wins over a simultaneous run.
  - DRAIN: counter decrements each cycle; counter==0 -> HALTED. run and step are ignored. A branch flush does not restart the counter.
  - HALTED: run=1 and halt_req=0 -> RUN. step=1 performs one active cycle and remains in HALTED.
  - HALTED with step and run both 1: the step is performed this cycle; the RUN transition also happens.
  - step held high for N cycles in HALTED gives N advance cycles. step is level-sampled, with no edge detection.
- Reset asserted mid-DRAIN or mid-stall: immediate IDLE with all outputs at reset values. No partial drain completes.
- No combinational path from any output back to any input.

Optional Feature:
- Macro: PIPE_CTRL_PERF_CNT_EN.
- Defined:
  - cycle_count increments every cycle in which state is RUN.
  - stall_count increments on each load-use stall cycle (in RUN, or HALTED with step).
  - flush_count increments on each branch-flush cycle.
  - All counters saturate at 2^CNT_W-1 and clear only on reset.
- Not defined: the three count outputs are tied to 0 and no counter flops are synthesized.

Test Plan:
1. Reset, then run=1 for 1 cycle -> next cycle state=01, pc_write=1, ifid_write=1, all flushes=0.
2. RUN; EX_MemRead=1, EX_rt=5, ID_rs=5 -> same cycle pc_write=0, ifid_write=0, idex_flush=1. With EX_rt=0 -> no stall.
3. RUN; MEM_branch_taken=1 while load-use also true -> pc_write=1, ifid_flush=idex_flush=exmem_flush=1; stall suppressed.
4. RUN; halt_req=1 at cycle t -> state=10 for cycles t+1..t+4 with pc_write=0, ifid_flush=1; state=11 at t+5.
5. HALTED; step pulsed 3 separate times -> exactly 3 cycles with pc_write=1; state stays 11. Then run=1 -> state=01.
6. Reset asserted asynchronously mid-DRAIN, off the clock edge -> state=00 and pc_write=0 immediately. With PIPE_CTRL_PERF_CNT_EN: counters=0; after 10 RUN cycles with 2 stalls, cycle_count=10, stall_count=2.
